// File: rtl/uart_pkg.sv
// Shared UART types and constants; the receive path will add its state enum here.
package uart_pkg;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Stop-bit lengths in baud ticks at the default oversample rate.
  localparam int unsigned STOP_TICKS_1   = 16;
  localparam int unsigned STOP_TICKS_1P5 = 24;
  localparam int unsigned STOP_TICKS_2   = 32;

  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmit engine: pops bytes from the TX FIFO head and serialises start/data/parity/stop.
// Define UART_TX_BREAK_EN to add lcr_bc_i, which holds tx_o low (line break) while set.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick_i,
  input  logic [1:0] lcr_wls_i,
  input  logic       lcr_stb_i,
  input  logic       lcr_pen_i,
  input  logic       lcr_eps_i,
  input  logic       lcr_sp_i,
`ifdef UART_TX_BREAK_EN
  input  logic       lcr_bc_i,
`endif
  input  logic [7:0] fifo_tx_i,
  input  logic       fifo_tx_empty_i,
  output logic       fifo_tx_pop_o,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned StopW = TickW + 3;
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [StopW-1:0] StopLast1 =
    StopW'(STOP_TICKS_1 * OVERSAMPLE / OVERSAMPLE_DEF - 1);
  localparam logic [StopW-1:0] StopLast15 =
    StopW'(STOP_TICKS_1P5 * OVERSAMPLE / OVERSAMPLE_DEF - 1);
  localparam logic [StopW-1:0] StopLast2 =
    StopW'(STOP_TICKS_2 * OVERSAMPLE / OVERSAMPLE_DEF - 1);

  tx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [1:0]       wls_q, wls_d;
  logic             pen_q, pen_d;
  logic             stb_q, stb_d;
  logic             tx_q, tx_d;

  logic             load;
  logic             bit_end;
  logic             line_d;
  logic [7:0]       load_data;
  logic [StopW-1:0] stop_cnt;
  logic [StopW-1:0] stop_last;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    wls_d      = wls_q;
    pen_d      = pen_q;
    stb_d      = stb_q;
    load       = 1'b0;
    load_data  = fifo_tx_i & wls_mask(lcr_wls_i);
    bit_end    = baud_tick_i && (tick_cnt_q == TickLast);
    // STOP counts ticks across bit periods, so bit_cnt extends tick_cnt there.
    stop_cnt   = {bit_cnt_q, tick_cnt_q};

    if (!stb_q) begin
      stop_last = StopLast1;
    end else if (wls_q == WLS_5) begin
      stop_last = StopLast15;
    end else begin
      stop_last = StopLast2;
    end

    unique case (state_q)
      TxIdle: load = !fifo_tx_empty_i;
      TxStart, TxParity: begin
        if (baud_tick_i) tick_cnt_d = tick_cnt_q + 1'b1;
        if (bit_end) begin
          state_d   = (state_q == TxStart) ? TxData : TxStop;
          bit_cnt_d = '0;
        end
      end
      TxData: begin
        if (baud_tick_i) tick_cnt_d = tick_cnt_q + 1'b1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == {1'b1, wls_q}) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? TxParity : TxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      TxStop: begin
        if (baud_tick_i) begin
          if (stop_cnt == stop_last) begin
            load       = !fifo_tx_empty_i;
            state_d    = TxIdle;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            {bit_cnt_d, tick_cnt_d} = stop_cnt + 1'b1;
          end
        end
      end
      default: state_d = TxIdle;
    endcase

    if (load) begin
      state_d    = TxStart;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = load_data;
      wls_d      = lcr_wls_i;
      pen_d      = lcr_pen_i;
      stb_d      = lcr_stb_i;
      parity_d   = lcr_sp_i ? ~lcr_eps_i : (lcr_eps_i ? ^load_data : ~^load_data);
    end

    unique case (state_d)
      TxIdle:   line_d = 1'b1;
      TxStart:  line_d = 1'b0;
      TxData:   line_d = shift_d[0];
      TxParity: line_d = parity_d;
      TxStop:   line_d = 1'b1;
      default:  line_d = 1'b1;
    endcase

`ifdef UART_TX_BREAK_EN
    tx_d = line_d & ~lcr_bc_i;
`else
    tx_d = line_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= TxIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wls_q      <= '0;
      pen_q      <= 1'b0;
      stb_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wls_q      <= wls_d;
      pen_q      <= pen_d;
      stb_q      <= stb_d;
      tx_q       <= tx_d;
    end
  end

  // Pop must coincide with the latching edge, so it cannot be registered.
  assign fifo_tx_pop_o = load & reset_n;
  assign tx_busy_o     = (state_q != TxIdle);
  assign tx_o          = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a FIFO model feeds bytes, a line monitor rebuilds each frame
// tick by tick and compares it with the frame queued when the byte was pushed.
module tb_uart_transmitter;

  localparam int Os      = 16;
  localparam int TickDiv = 4;

  typedef struct {
    logic [255:0] lv;
    int           len;
    logic [7:0]   d;
    int           n;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_tick_i;
  logic [1:0] lcr_wls_i;
  logic       lcr_stb_i;
  logic       lcr_pen_i;
  logic       lcr_eps_i;
  logic       lcr_sp_i;
  logic [7:0] fifo_tx_i;
  logic       fifo_tx_empty_i;
  logic       fifo_tx_pop_o;
  logic       tx_o;
  logic       tx_busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;
  int tick_div_cnt = 0;

  logic [7:0]   fifo_q[$];
  frame_t       sb[$];
  frame_t       cur;
  logic [255:0] obs;
  int           idx;
  logic         collecting = 1'b0;
  logic         expect_start = 1'b0;
  logic         mon_en = 1'b0;
  logic         mon_load;
  logic [7:0]   mon_dec;

  uart_transmitter #(.OVERSAMPLE(Os)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .baud_tick_i     (baud_tick_i),
    .lcr_wls_i       (lcr_wls_i),
    .lcr_stb_i       (lcr_stb_i),
    .lcr_pen_i       (lcr_pen_i),
    .lcr_eps_i       (lcr_eps_i),
    .lcr_sp_i        (lcr_sp_i),
`ifdef UART_TX_BREAK_EN
    .lcr_bc_i        (1'b0),
`endif
    .fifo_tx_i       (fifo_tx_i),
    .fifo_tx_empty_i (fifo_tx_empty_i),
    .fifo_tx_pop_o   (fifo_tx_pop_o),
    .tx_o            (tx_o),
    .tx_busy_o       (tx_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk_frame(input logic [7:0] b, input logic [1:0] wls,
                                      input logic pen, input logic eps, input logic sp,
                                      input logic stb);
    frame_t f;
    int     pos;
    int     ones;
    int     stop_len;
    logic   par;
    f.lv = '0;
    f.d  = '0;
    f.n  = 5 + int'(wls);
    pos  = 0;
    ones = 0;
    for (int i = 0; i < Os; i++) begin
      f.lv[pos] = 1'b0;
      pos++;
    end
    for (int k = 0; k < f.n; k++) begin
      f.d[k] = b[k];
      ones += int'(b[k]);
      for (int i = 0; i < Os; i++) begin
        f.lv[pos] = b[k];
        pos++;
      end
    end
    if (pen) begin
      if (sp) par = !eps;
      else if (eps) par = ((ones % 2) == 1);
      else par = ((ones % 2) == 0);
      for (int i = 0; i < Os; i++) begin
        f.lv[pos] = par;
        pos++;
      end
    end
    if (!stb) stop_len = Os;
    else if (wls == 2'b00) stop_len = Os + Os / 2;
    else stop_len = 2 * Os;
    for (int i = 0; i < stop_len; i++) begin
      f.lv[pos] = 1'b1;
      pos++;
    end
    f.len = pos;
    return f;
  endfunction

  task automatic fifo_refresh();
    fifo_tx_empty_i = (fifo_q.size() == 0);
    fifo_tx_i       = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    n_push++;
    fifo_refresh();
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] wls, input logic pen,
                      input logic eps, input logic sp, input logic stb);
    lcr_wls_i = wls;
    lcr_pen_i = pen;
    lcr_eps_i = eps;
    lcr_sp_i  = sp;
    lcr_stb_i = stb;
    sb.push_back(mk_frame(b, wls, pen, eps, sp, stb));
    fifo_push(b);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || collecting || tx_busy_o || fifo_q.size() != 0) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_within_budget", cyc < 6000, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  // Baud tick: one clock in TickDiv, changed just after the edge so it is stable at negedge.
  initial begin
    baud_tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick_i  = (tick_div_cnt == TickDiv - 1);
      tick_div_cnt = (tick_div_cnt + 1) % TickDiv;
    end
  end

  // FIFO model: drops the head after the DUT pops it.
  initial begin
    forever begin
      @(posedge clk);
      if (fifo_tx_pop_o) begin
        check("pop_nonempty", fifo_q.size() != 0, 1'b1);
        n_pop++;
        #1;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  // Line monitor, sampled in baud-tick cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (baud_tick_i) begin
        if (expect_start) begin
          check("b2b_no_gap", tx_o, 1'b0);
          expect_start = 1'b0;
        end
        if (collecting) begin
          obs[idx] = tx_o;
          idx++;
          if (idx == cur.len) begin
            mon_load = !fifo_tx_empty_i;
            check("busy_at_stop_end", tx_busy_o, 1'b1);
            check("pop_at_stop_end", fifo_tx_pop_o, mon_load);
            check("frame_levels", obs, cur.lv);
            mon_dec = '0;
            for (int k = 0; k < cur.n; k++) mon_dec[k] = obs[(1 + k) * Os + Os / 2];
            check("frame_data", mon_dec, cur.d);
            collecting = 1'b0;
            @(negedge clk);
            check("busy_after_stop", tx_busy_o, mon_load);
            expect_start = mon_load;
          end
        end else if (mon_en && tx_o == 1'b0) begin
          check("frame_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            cur        = sb.pop_front();
            obs        = '0;
            idx        = 1;
            collecting = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int cyc;
    reset_n   = 1'b0;
    lcr_wls_i = 2'b11;
    lcr_stb_i = 1'b0;
    lcr_pen_i = 1'b0;
    lcr_eps_i = 1'b0;
    lcr_sp_i  = 1'b0;
    fifo_refresh();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 0xA5, queued while reset is still held.
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_pop", fifo_tx_pop_o, 1'b0);
    check("rst_tx", tx_o, 1'b1);
    check("rst_busy", tx_busy_o, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle();

    // 7E1 / 7O1 on 0x35.
    send(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle();
    send(8'h35, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Stick parity.
    send(8'hFF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle();
    send(8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle();
    send(8'hFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();
    send(8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();

    // Long stop bits.
    send(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    send(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back.
    p0 = n_pop;
    send(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h33, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("b2b_pops", n_pop - p0, 3);

    // Reset during DATA of 0x5A, with 0x77 waiting in the FIFO.
    mon_en    = 1'b0;
    lcr_wls_i = 2'b11;
    lcr_pen_i = 1'b0;
    lcr_stb_i = 1'b0;
    fifo_push(8'h5A);
    cyc = 0;
    while (fifo_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_frame_loaded", fifo_q.size(), 0);
    repeat (200) @(negedge clk);
    check("in_data_busy", tx_busy_o, 1'b1);
    reset_n = 1'b0;
    fifo_push(8'h77);
    #1;
    check("rst_mid_pop", fifo_tx_pop_o, 1'b0);
    @(negedge clk);
    check("rst_mid_tx", tx_o, 1'b1);
    check("rst_mid_busy", tx_busy_o, 1'b0);
    check("rst_mid_fifo_kept", fifo_q.size(), 1);
    sb.push_back(mk_frame(8'h77, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_idle();

    // LCR change after load must not affect the frame in flight.
    send(8'hE6, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (fifo_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    lcr_wls_i = 2'b11;
    lcr_pen_i = 1'b0;
    lcr_stb_i = 1'b1;
    wait_idle();

    check("pop_count", n_pop, n_push);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
